mem_access_stage: RTL and testbench

//  - Consumer of the EX/MEM pipeline register: MEM stage plus MEM/WB register for the 5-stage pipeline.
//  - Turns memRead/memWrite with ALUresult/writedata into a req/ack transaction on a data-memory port.
//  - Stalls the upstream pipeline until the transaction completes.
//  - Registers the write-back bundle (or a bubble) for WB.

---
 rtl/mem_access_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage and MEM/WB register of the 5-stage pipeline.
// Turns EX/MEM load/store controls into a req/ack data-memory transaction, stalls
// upstream until completion, and registers the write-back bundle (or a bubble).
// Optional feature: define MEM_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES cycles.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        memtoReg,
  input  logic        regWrite,
  input  logic [31:0] ALUresult,
  input  logic [31:0] writedata,
  input  logic [4:0]  reg_dst,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        regWrite_out,
  output logic        memtoReg_out,
  output logic [31:0] ALUresult_out,
  output logic [31:0] readdata_out,
  output logic [4:0]  reg_dst_out,
  output logic        mem_err
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        rw_q, rw_d;
  logic        m2r_q, m2r_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  dst_q, dst_d;

  logic acc, fault, in_idle, in_wait, timeout, stall_raw, wb_capture;

  assign acc     = memRead | memWrite;
  assign fault   = acc & ((ALUresult[1:0] != 2'b00) | (memRead & memWrite));
  assign in_idle = (state_q == StIdle);
  assign in_wait = (state_q == StWait);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;

  // Wait counter: cleared while idle (so it starts at 0 on WAIT entry).
  always_comb begin
    cnt_d = 8'd0;
    if (in_wait && !dmem_ack) cnt_d = cnt_q + 8'd1;
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign timeout = in_wait & ~dmem_ack & (cnt_q == CntLast);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  assign stall_raw  = (in_idle & acc & ~fault) | (in_wait & ~dmem_ack & ~timeout);
  // Reset forces every output low, including the combinational stall.
  assign stall      = reset & stall_raw;
  assign wb_capture = ~stall_raw & ~(in_idle & fault) & ~timeout;

  // Next-state for the transaction FSM, the memory port and the WB bundle.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    dst_d   = dst_q;
    rw_d    = 1'b0;
    m2r_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (acc && !fault) begin
          req_d   = 1'b1;
          we_d    = memWrite;
          addr_d  = ALUresult;
          wdata_d = writedata;
          state_d = StWait;
        end else if (fault) begin
          err_d = 1'b1;
        end
      end
      StWait: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          state_d = StIdle;
          if (!we_q) rdata_d = dmem_rdata;
        end else if (timeout) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (wb_capture) begin
      rw_d  = regWrite;
      m2r_d = memtoReg;
      alu_d = ALUresult;
      dst_d = reg_dst;
    end
  end

  // State, memory-port and MEM/WB registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      alu_q   <= 32'd0;
      rdata_q <= 32'd0;
      dst_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      dst_q   <= dst_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign mem_err       = err_q;
  assign regWrite_out  = rw_q;
  assign memtoReg_out  = m2r_q;
  assign ALUresult_out = alu_q;
  assign readdata_out  = rdata_q;
  assign reg_dst_out   = dst_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// instruction stream checked against a per-instruction timing/value model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead, memWrite, memtoReg, regWrite;
  logic [31:0] ALUresult, writedata, dmem_rdata;
  logic [4:0]  reg_dst;
  logic        dmem_ack;
  logic        stall, dmem_req, dmem_we, regWrite_out, memtoReg_out, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, ALUresult_out, readdata_out;
  logic [4:0]  reg_dst_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rdata;  // model of the last completed load data

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .memtoReg(memtoReg), .regWrite(regWrite), .ALUresult(ALUresult),
    .writedata(writedata), .reg_dst(reg_dst), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .regWrite_out(regWrite_out),
    .memtoReg_out(memtoReg_out), .ALUresult_out(ALUresult_out),
    .readdata_out(readdata_out), .reg_dst_out(reg_dst_out), .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst);
    memRead = rd; memWrite = wr; memtoReg = m2r; regWrite = rw;
    ALUresult = alu; writedata = wd; reg_dst = dst;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
    chk({tag, ".we"}, {31'd0, dmem_we}, 32'd0);
    chk({tag, ".addr"}, dmem_addr, 32'd0);
    chk({tag, ".wdata"}, dmem_wdata, 32'd0);
    chk({tag, ".err"}, {31'd0, mem_err}, 32'd0);
    chk({tag, ".rw"}, {31'd0, regWrite_out}, 32'd0);
    chk({tag, ".m2r"}, {31'd0, memtoReg_out}, 32'd0);
    chk({tag, ".aluo"}, ALUresult_out, 32'd0);
    chk({tag, ".rdo"}, readdata_out, 32'd0);
    chk({tag, ".dst"}, {27'd0, reg_dst_out}, 32'd0);
  endtask

  // One instruction: n_wait = WAIT cycles without ack before the ack cycle.
  // Model: a clean access stalls for 1 + n_wait cycles and writes back on the ack edge;
  // a fault or non-access takes one cycle.
  task automatic do_instr(input logic rd, input logic wr, input logic m2r, input logic rw,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst,
                          input int n_wait, input logic [31:0] rdata);
    logic acc_m, fault_m;
    acc_m   = rd | wr;
    fault_m = acc_m && ((alu % 4) != 0 || (rd && wr));
    @(negedge clk);
    drive(rd, wr, m2r, rw, alu, wd, dst);
    dmem_ack = 1'b0;
    #1;
    chk("idle.stall", {31'd0, stall}, {31'd0, acc_m && !fault_m});
    chk("idle.req", {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    if (acc_m && !fault_m) begin
      chk("issue.req", {31'd0, dmem_req}, 32'd1);
      chk("issue.we", {31'd0, dmem_we}, {31'd0, wr});
      chk("issue.addr", dmem_addr, alu);
      chk("issue.wdata", dmem_wdata, wd);
      chk("issue.bubble", {30'd0, regWrite_out, memtoReg_out}, 32'd0);
      for (int i = 0; i < n_wait; i++) begin
        @(negedge clk); #1;
        chk("wait.stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        chk("wait.req", {31'd0, dmem_req}, 32'd1);
        chk("wait.addr", dmem_addr, alu);
        chk("wait.bubble", {31'd0, regWrite_out}, 32'd0);
      end
      @(negedge clk);
      dmem_ack = 1'b1; dmem_rdata = rdata;
      #1;
      chk("ack.stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (rd) exp_rdata = rdata;
      chk("done.req", {31'd0, dmem_req}, 32'd0);
      chk("done.rdata", readdata_out, exp_rdata);
      chk("done.err", {31'd0, mem_err}, 32'd0);
      chk("done.rw", {31'd0, regWrite_out}, {31'd0, rw});
      chk("done.m2r", {31'd0, memtoReg_out}, {31'd0, m2r});
      chk("done.alu", ALUresult_out, alu);
      chk("done.dst", {27'd0, reg_dst_out}, {27'd0, dst});
    end else if (fault_m) begin
      chk("fault.err", {31'd0, mem_err}, 32'd1);
      chk("fault.req", {31'd0, dmem_req}, 32'd0);
      chk("fault.bubble", {30'd0, regWrite_out, memtoReg_out}, 32'd0);
    end else begin
      chk("alu.err", {31'd0, mem_err}, 32'd0);
      chk("alu.req", {31'd0, dmem_req}, 32'd0);
      chk("alu.rw", {31'd0, regWrite_out}, {31'd0, rw});
      chk("alu.m2r", {31'd0, memtoReg_out}, {31'd0, m2r});
      chk("alu.alu", ALUresult_out, alu);
      chk("alu.dst", {27'd0, reg_dst_out}, {27'd0, dst});
    end
  endtask

  // Watchdog: the stimulus is fixed-length, so this only fires on a bench bug.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, nw;
    int stall_cnt;
    logic [31:0] a;
    reset = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    exp_rdata = 32'd0;
    #3;
    chk_all_zero("reset");
    @(negedge clk); reset = 1'b1;

    // Directed cases.
    do_instr(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'd0, 5'd5, 0, 32'd0);
    do_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'd0, 5'd7, 3, 32'hCAFE_F00D);
    do_instr(1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 32'h1234_5678, 5'd0, 0, 32'hDEAD_BEEF);
    do_instr(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'd0, 5'd3, 0, 32'd0);
    do_instr(1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 32'h55, 5'd4, 0, 32'd0);
    do_instr(1'b0, 1'b0, 1'b0, 1'b1, 32'h3, 32'd0, 5'd9, 0, 32'd0);

    // Async reset while waiting for ack.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd6);
    @(posedge clk); #1;
    chk("rst.req_before", {31'd0, dmem_req}, 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk_all_zero("rstwait");
    exp_rdata = 32'd0;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    reset = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("spur.stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("spur.req", {31'd0, dmem_req}, 32'd0);
    chk("spur.rdata", readdata_out, 32'd0);
    chk("spur.rw", {31'd0, regWrite_out}, 32'd0);

    // Randomized stream: ALU ops, loads, stores and both fault flavours back to back.
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 4);
      nw   = $urandom_range(0, 3);
      a    = $urandom & 32'hFFFF_FFFC;
      case (kind)
        0: do_instr(1'b0, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom,
                    5'($urandom), 0, 32'd0);
        1: do_instr(1'b1, 1'b0, 1'b1, 1'b1, a, $urandom, 5'($urandom), nw, $urandom);
        2: do_instr(1'b0, 1'b1, 1'b0, 1'b0, a, $urandom, 5'($urandom), nw, $urandom);
        3: do_instr(1'($urandom), 1'b1, 1'b0, 1'b1, a | 32'(2'($urandom_range(1, 3))),
                    $urandom, 5'($urandom), 0, 32'd0);
        default: do_instr(1'b1, 1'b1, 1'b1, 1'b1, a, $urandom, 5'($urandom), 0, 32'd0);
      endcase
    end

    // Ack never arrives.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 5'd8);
    dmem_ack = 1'b0;
    @(posedge clk); #1;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("to.stall", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
      chk("to.req", {31'd0, dmem_req}, 32'd1);
    end
    @(negedge clk); #1;
    chk("to.last_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    chk("to.req_drop", {31'd0, dmem_req}, 32'd0);
    chk("to.err", {31'd0, mem_err}, 32'd1);
    chk("to.bubble", {30'd0, regWrite_out, memtoReg_out}, 32'd0);
    chk("to.rdata", readdata_out, exp_rdata);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    @(posedge clk); #1;
    chk("to.err_pulse", {31'd0, mem_err}, 32'd0);
`else
    stall_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk); #1;
      if (stall && dmem_req) stall_cnt++;
    end
    chk("hang.stall_cycles", stall_cnt, 32'd22);
    reset = 1'b0;
    #1;
    chk("hang.reset_req", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    reset = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
